// File: rtl/fir8_sum_pipeline.sv
// Final reduction stage of the 8-tap FIR adder layer: pairwise add, final add,
// then round/shift/saturate, with a stall-all valid/ready pipeline and clip counter.
module fir8_sum_pipeline #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int SHIFT = 2,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  s0,
  input  logic signed [IN_W-1:0]  s1,
  input  logic signed [IN_W-1:0]  s2,
  input  logic signed [IN_W-1:0]  s3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y,
  output logic                    clipped,
  output logic [CNT_W-1:0]        clip_count,
  input  logic                    clr_count
);

  localparam int RW = IN_W + 3;

  logic                    en;
  logic                    v1;
  logic                    v2;
  logic signed [IN_W:0]    p0;
  logic signed [IN_W:0]    p1;
  logic signed [IN_W+1:0]  t;
  logic signed [RW-1:0]    tx;
  logic signed [RW-1:0]    r;
  logic signed [OUT_W-1:0] y_sat;
  logic                    clip_n;

  // One enable for every stage: any stall at the sink freezes the whole pipe.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign tx = RW'(t);

  if (SHIFT > 0) begin : g_round
    localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
    assign r = (tx + HALF) >>> SHIFT;
  end else begin : g_pass
    assign r = tx;
  end

  if (OUT_W < RW) begin : g_sat
    localparam logic signed [RW-1:0] YMAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] YMIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    always_comb begin
      clip_n = 1'b0;
      y_sat  = r[OUT_W-1:0];
      if (r > YMAX) begin
        clip_n = 1'b1;
        y_sat  = YMAX[OUT_W-1:0];
      end else if (r < YMIN) begin
        clip_n = 1'b1;
        y_sat  = YMIN[OUT_W-1:0];
      end
    end
  end else begin : g_nosat
    assign clip_n = 1'b0;
    assign y_sat  = OUT_W'(r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      p0        <= '0;
      p1        <= '0;
      t         <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      clipped   <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      p0        <= (IN_W+1)'(s0) + (IN_W+1)'(s1);
      p1        <= (IN_W+1)'(s2) + (IN_W+1)'(s3);
      v2        <= v1;
      t         <= (IN_W+2)'(p0) + (IN_W+2)'(p1);
      out_valid <= v2;
      y         <= y_sat;
      clipped   <= clip_n;
    end
  end

  // Counts clipped samples actually taken by the sink; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_count <= '0;
    end else if (clr_count) begin
      clip_count <= '0;
    end else if (out_valid && out_ready && clipped && (clip_count != '1)) begin
      clip_count <= clip_count + CNT_W'(1);
    end
  end

endmodule
